sirv_plic_arbiter: RTL



---
 rtl/sirv_plic_pkg.sv | 15 +
 rtl/sirv_plic_max_tree.sv | 52 +++++
 rtl/sirv_plic_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/sirv_plic_pkg.sv
// Shared PLIC constants: default sizing and the "no source" ID.
// Imported by the arbiter and the priority max tree.
package sirv_plic_pkg;

    localparam int PLIC_NSRC    = 8;
    localparam int PLIC_PRIO_W  = 3;
    localparam int PLIC_ID_W    = 4;
    localparam int PLIC_ID_NONE = 0;

    // Minimum ID width able to encode IDs 0..nsrc.
    function automatic int plic_id_bits(input int nsrc);
        return $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/sirv_plic_max_tree.sv
// Log-depth (priority, id) maximum over a candidate vector.
// Ties go to the lowest ID; a zero-priority result reports ID none.
module sirv_plic_max_tree
    import sirv_plic_pkg::*;
#(
    parameter int NSRC   = PLIC_NSRC,
    parameter int PRIO_W = PLIC_PRIO_W,
    parameter int ID_W   = PLIC_ID_W
) (
    input  logic [NSRC-1:0]        i_valid,
    input  logic [NSRC*PRIO_W-1:0] i_prio,
    output logic [ID_W-1:0]        o_id,
    output logic [PRIO_W-1:0]      o_prio
);

    localparam int LV = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int W  = 1 << LV;

    logic [PRIO_W-1:0] w_p [LV+1][W];
    logic [ID_W-1:0]   w_i [LV+1][W];

    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            for (int k = 0; k < W; k++) begin
                w_p[l][k] = '0;
                w_i[l][k] = '0;
            end
        end
        for (int k = 0; k < NSRC; k++) begin
            if (i_valid[k]) begin
                w_p[0][k] = i_prio[k*PRIO_W +: PRIO_W];
                w_i[0][k] = ID_W'(k + 1);
            end
        end
        // Left operand always holds the lower IDs, so only a strict win moves right.
        for (int l = 0; l < LV; l++) begin
            for (int k = 0; k < (W >> (l + 1)); k++) begin
                if (w_p[l][2*k+1] > w_p[l][2*k]) begin
                    w_p[l+1][k] = w_p[l][2*k+1];
                    w_i[l+1][k] = w_i[l][2*k+1];
                end else begin
                    w_p[l+1][k] = w_p[l][2*k];
                    w_i[l+1][k] = w_i[l][2*k];
                end
            end
        end
    end

    assign o_prio = w_p[LV][0];
    assign o_id   = (w_p[LV][0] == '0) ? ID_W'(PLIC_ID_NONE) : w_i[LV][0];

endmodule

// File: rtl/sirv_plic_arbiter.sv
// PLIC pending/claim/complete stage fed by the per-source gateways.
// Registers the best enabled pending source above threshold for one hart.
module sirv_plic_arbiter
    import sirv_plic_pkg::*;
#(
    parameter int NSRC   = PLIC_NSRC,
    parameter int PRIO_W = PLIC_PRIO_W,
    parameter int ID_W   = PLIC_ID_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NSRC-1:0]        io_gw_valid,
    output logic [NSRC-1:0]        io_gw_ready,
    output logic [NSRC-1:0]        io_gw_complete,
    input  logic [NSRC*PRIO_W-1:0] io_prio,
    input  logic [NSRC-1:0]        io_enable,
    input  logic [PRIO_W-1:0]      io_threshold,
    output logic                   io_irq,
    input  logic                   io_claim_valid,
    output logic [ID_W-1:0]        io_claim_id,
    input  logic                   io_complete_valid,
    input  logic [ID_W-1:0]        io_complete_id
);

    logic [NSRC-1:0]   r_pending;
    logic [ID_W-1:0]   r_best_id;
    logic              r_irq;
    logic [NSRC-1:0]   r_gw_complete;

    logic [NSRC-1:0]   w_set;
    logic [NSRC-1:0]   w_claim_clr;
    logic [NSRC-1:0]   w_cmp_hit;
    logic [NSRC-1:0]   w_pending_d;
    logic [NSRC-1:0]   w_cand;
    logic [ID_W-1:0]   w_best_id;
    logic [PRIO_W-1:0] w_best_prio;

    assign io_gw_ready    = ~r_pending;
    assign io_gw_complete = r_gw_complete;
    assign io_irq         = r_irq;
    assign io_claim_id    = r_irq ? r_best_id : ID_W'(PLIC_ID_NONE);

    assign w_set = io_gw_valid & ~r_pending;

    // Out-of-range and zero IDs match no source and fall through.
    always_comb begin
        w_claim_clr = '0;
        w_cmp_hit   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (io_claim_valid && io_claim_id == ID_W'(i + 1))
                w_claim_clr[i] = 1'b1;
            if (io_complete_valid && io_complete_id == ID_W'(i + 1)
                && io_enable[i])
                w_cmp_hit[i] = 1'b1;
        end
    end

    // Select on next-state pending so a claimed source never reappears.
    assign w_pending_d = (r_pending | w_set) & ~w_claim_clr;
    assign w_cand      = w_pending_d & io_enable;

    sirv_plic_max_tree #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_max_tree (
        .i_valid (w_cand),
        .i_prio  (io_prio),
        .o_id    (w_best_id),
        .o_prio  (w_best_prio)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending     <= '0;
            r_best_id     <= '0;
            r_irq         <= 1'b0;
            r_gw_complete <= '0;
        end else begin
            r_pending     <= w_pending_d;
            r_best_id     <= w_best_id;
            r_irq         <= (w_best_prio > io_threshold);
            r_gw_complete <= w_cmp_hit;
        end
    end

endmodule
